even_parity_serial_tx: RTL
==========================

Name: even_parity_serial_tx

Overview:
- Transmit end of the team's even-parity link; pairs with the existing parity checker on the receive side.
- Accepts a parallel word over a valid/ready handshake and computes the even-parity bit (XOR of all data bits), so the total count of ones in data plus parity is even.
- Serialises one frame: start bit, data bits LSB first, parity bit, stop bit.
- Sits between a word producer and the single-wire serial line.

Parameters:
- DATA_W, 8, data bits per frame (legal range 1..16).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_out (legal range 1..255).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  word to send; sampled only on handshake.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word.
- tx_out  output  1  serial line; idle level 1.
- busy  output  1  high while a frame is on the line.
- parity_out  output  1  parity bit of the word currently being sent; holds the last value after the frame.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset values: tx_out=1, in_ready=0 during reset (1 from the first cycle after), busy=0, parity_out=0, frame_done=0; state IDLE; counters 0.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- in_ready = (state==IDLE) && !rst. Handshake = in_valid && in_ready at a rising edge.
- On handshake:
  - latch in_data into a shift register;
  - parity_out <= ^in_data;
  - enter START.
  - tx_out=0 and busy=1 from the next cycle.
- The bit counter runs 0..CLKS_PER_BIT-1. Each state holds for CLKS_PER_BIT cycles.
- START: tx_out=0.
- DATA: tx_out = shift_reg[0]. The register shifts right at the end of each bit period. The bit index counts 0..DATA_W-1; the state leaves DATA after bit DATA_W-1.
- PARITY: tx_out = parity_out.
- STOP: tx_out=1. frame_done=1 on its final cycle, then return to IDLE.
- Frame length is (DATA_W+3)*CLKS_PER_BIT cycles. in_ready reasserts the cycle after frame_done, so the minimum gap between frames is 1 idle cycle (tx_out=1).
- in_valid while not ready is ignored, and in_data changes mid-frame have no effect. The producer holds in_valid and in_data until the handshake.
- Arithmetic:
  - counter widths are $clog2 of each range, minimum 1;
  - no wrap beyond terminal counts; counters reset to 0 on every state change.
- Reset mid-frame: at the next edge, tx_out=1, state IDLE, busy=0, frame_done=0. The word is abandoned and no partial parity or stop bit is sent.
- In the CLKS_PER_BIT=1 and DATA_W=1 corner cases, every state lasts exactly one cycle. No state is skipped.

Decomposition:
- Shared package: the state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit), the line levels (LINE_IDLE=1, START_LVL=0, STOP_LVL=1), and the parity function (even = XOR reduce). The checker reuses these.
- One natural sub-module: even_parity_gen, a combinational XOR reduce of DATA_W bits giving the parity bit. It is shared with the checker, which XORs the received parity with its own result to produce its error output.

Test Plan:
- Reset for 2 cycles, then release -> tx_out=1, busy=0, frame_done=0; in_ready=1 on the first cycle after release.
- DATA_W=8, CLKS_PER_BIT=4, send 8'hA5 (four ones) -> the line carries 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1, each bit held 4 cycles. parity_out=0. frame_done pulses at cycle 44 after the handshake. in_ready returns at cycle 45.
- Send 8'h07 (three ones) -> parity bit on the line =1, parity_out=1. A loopback through the existing checker reports no error for every word 8'h00..8'hFF.
- Hold in_valid high with 8'h01 then 8'hFF back-to-back -> the second handshake occurs exactly 1 idle cycle after frame_done. in_ready stays 0 throughout the first frame and the data change has no effect on it.
- Assert rst during the DATA state (3rd bit) -> tx_out=1 and busy=0 on the next edge, with no frame_done pulse. A new word is accepted on the first cycle after rst deasserts.
- CLKS_PER_BIT=1, DATA_W=1, send 1'b1 -> the line carries 0,1,1,1 over 4 consecutive cycles and frame_done pulses on the 4th.

Source files
------------

// File: rtl/even_parity_serial_tx_pkg.sv
// even_parity_serial_tx_pkg
// Shared definitions for the even-parity serial link: the transmitter state
// encoding, the idle/start/stop line levels and the even-parity function.
// The receive-side checker imports the same package so both ends agree.
package even_parity_serial_tx_pkg;

   // Transmitter frame states, fixed encoding shared with the checker
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } txState_e;

   // Serial line levels
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   // Widest word the link carries; narrower words are zero-extended,
   // which leaves the parity unchanged
   localparam int MAX_DATA_W = 16;

   // Even parity bit: makes the total count of ones (data + parity) even
   function automatic logic evenParity(input logic [MAX_DATA_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/even_parity_serial_tx_gen.sv
// even_parity_gen
// Combinational even-parity generator for a DATA_W-bit word. Shared with
// the receive-side checker, which XORs the received parity bit with this
// result to flag an error.
// Ports:
//   data_i   [DATA_W-1:0]  word to protect
//   parity_o               even-parity bit (XOR of all data bits)
module even_parity_gen
   import even_parity_serial_tx_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data_i,
   output logic              parity_o
);

   // Zero-extend to the package width so one function serves every DATA_W
   assign parity_o = evenParity(MAX_DATA_W'(data_i));

endmodule

// File: rtl/even_parity_serial_tx.sv
// even_parity_serial_tx
// Transmit end of the even-parity link. Accepts a parallel word over a
// valid/ready handshake and sends one frame: start bit, data LSB first,
// even-parity bit, stop bit. Every bit is held for CLKS_PER_BIT cycles.
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   in_data     word to send, sampled only on the handshake
//   in_valid    producer has a word
//   in_ready    block can accept a word (idle and not in reset)
//   tx_out      serial line, idles high
//   busy        high while a frame is on the line
//   parity_out  parity of the word being sent, held after the frame
//   frame_done  one-cycle pulse on the last cycle of the stop bit
module even_parity_serial_tx
   import even_parity_serial_tx_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              parity_out,
   output logic              frame_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

   txState_e          state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BIT_W-1:0]  bitIdx_q, bitIdx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              parity_q, parity_d;
   logic              txLine_q, txLine_d;
   logic              busy_q;
   logic              frameDone_q, frameDone_d;
   logic              lastTick;
   logic              wordParity;

   // Parity of the incoming word, captured alongside the data on handshake
   even_parity_gen #(
      .DATA_W (DATA_W)
   ) parityGen (
      .data_i   (in_data),
      .parity_o (wordParity)
   );

   // Ready is combinational so a word can be taken on the very first cycle
   // after reset releases and one cycle after each frame ends
   assign in_ready = (state_q == IDLE) && !rst;

   // Next-state logic: every state holds for CLKS_PER_BIT cycles and the
   // tick counter restarts at zero on each state change. The data shift
   // register moves right at the end of each data bit so bit 0 is always
   // the one on the line. The line level, busy and frame_done are derived
   // from the next state so they can be registered without a cycle of lag.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bitIdx_d    = bitIdx_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      txLine_d    = LINE_IDLE;
      frameDone_d = 1'b0;
      lastTick    = (cnt_q == LAST_TICK);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d  = START;
               cnt_d    = '0;
               bitIdx_d = '0;
               shift_d  = in_data;
               parity_d = wordParity;
            end
         end
         START: begin
            if (lastTick) begin
               state_d = DATA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (lastTick) begin
               cnt_d = '0;
               if (bitIdx_q == LAST_BIT) begin
                  state_d = PARITY;
               end else begin
                  bitIdx_d = bitIdx_q + BIT_W'(1);
                  shift_d  = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PARITY: begin
            if (lastTick) begin
               state_d = STOP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (lastTick) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      case (state_d)
         START:   txLine_d = START_LVL;
         DATA:    txLine_d = shift_d[0];
         PARITY:  txLine_d = parity_d;
         STOP:    txLine_d = STOP_LVL;
         default: txLine_d = LINE_IDLE;
      endcase

      frameDone_d = (state_d == STOP) && (cnt_d == LAST_TICK);
   end

   // State and registered outputs. Reset abandons any frame in progress:
   // the line goes straight back to idle with no parity or stop bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bitIdx_q    <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         txLine_q    <= LINE_IDLE;
         busy_q      <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bitIdx_q    <= bitIdx_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         txLine_q    <= txLine_d;
         busy_q      <= (state_d != IDLE);
         frameDone_q <= frameDone_d;
      end
   end

   assign tx_out     = txLine_q;
   assign busy       = busy_q;
   assign parity_out = parity_q;
   assign frame_done = frameDone_q;

endmodule
